tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 The block SHALL have these parameters: LEN_W, default 8, burst length field width; TIMEOUT, default 255, max FETCH wait in clk cycles.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates occur on its falling edge.
REQ-003 The block SHALL have port rstb, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req, input, 2, request per source: bit0 = FFT, bit1 = FIR.
REQ-005 The block SHALL have ports req_len0 and req_len1, input, LEN_W, payload word count per source, sampled at grant.
REQ-006 The block SHALL have ports src_data0 and src_data1, input, 16, source payload words.
REQ-007 The block SHALL have ports src_valid0 and src_valid1, input, 1, source word available.
REQ-008 The block SHALL have ports src_ready0 and src_ready1, output, 1, arbiter accepts a word this cycle.
REQ-009 The block SHALL have port grant, output, 2, one-hot owner of the transmit channel; 0 when idle.
REQ-010 The block SHALL have port tx_done, input, 1, transmitter completion; a rising edge means the current word was sent.
REQ-011 The block SHALL have port data_out, output, 16, word presented to the transmitter.
REQ-012 The block SHALL have port data_out_valid, output, 1, one-cycle pulse marking a new data_out.
REQ-013 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 The block SHALL have port timeout_err, output, 1, sticky flag for an aborted packet.

Function
REQ-015 The FSM SHALL have four states (IDLE, SEND, WAIT, FETCH) with this fixed flow: IDLE -> SEND -> WAIT -> (FETCH -> SEND -> WAIT)* -> IDLE.
REQ-016 IDLE SHALL grant the requester whose req bit is set and whose req_len is nonzero; if both qualify, the round-robin pointer decides (0 = FFT, 1 = FIR).
REQ-017 A request with req_len = 0 SHALL be ignored: no grant, no error.
REQ-018 On grant, the block SHALL latch source and length, set cnt = 0, load the header into data_out, and enter SEND.
REQ-019 The header word SHALL be: [15:8] = latched length, [7:2] = 0, [1:0] = mode (00 FFT, 01 FIR).
REQ-020 SEND SHALL drive data_out_valid = 1 for exactly one cycle, then enter WAIT; data_out holds its value until the next load.
REQ-021 WAIT SHALL act only on a tx_done rising edge, detected with a registered tx_done_prev; tx_done edges in any other state are ignored.
REQ-022 In WAIT on an edge: if cnt == length, the block SHALL clear grant, toggle the pointer to the other source, and enter IDLE; else it SHALL increment cnt and enter FETCH.
REQ-023 FETCH SHALL drive src_ready high only for the granted source; in the cycle src_valid is also high, it SHALL capture src_data into data_out and enter SEND.
REQ-024 Each FETCH visit SHALL count cycles from 0; on reaching TIMEOUT without a word, the block SHALL set timeout_err, clear grant, toggle the pointer, and enter IDLE.
REQ-025 Once granted, the block SHALL ignore changes to req, req_len, and src_valid of the non-granted source until the packet ends.
REQ-026 A req bit held high SHALL be eligible again in the first IDLE cycle after its packet; a new grant is issued in that same IDLE cycle.
REQ-027 cnt SHALL be LEN_W bits wide and never wraps, because it stops at length.
REQ-028 A maximum-length packet (255 words) SHALL send 256 words including the header.
REQ-029 timeout_err SHALL clear only on reset.

Reset
REQ-030 When rstb is low, the block SHALL immediately force: state = IDLE, grant = 0, src_ready0/1 = 0, data_out = 0, data_out_valid = 0, busy = 0, timeout_err = 0, pointer = 0, cnt = 0, tx_done_prev = 0.
REQ-031 Reset asserted mid-packet SHALL discard the packet; after release, the block SHALL resume in IDLE with no partial replay.

Structure
REQ-032 The shared package core_pkg SHALL hold the arb_state_t enum, MODE_FFT = 2'b00, MODE_FIR = 2'b01, and the default TIMEOUT.
REQ-033 The block SHALL contain one sub-module, rise_detect (registered rising-edge detector), instantiated for tx_done.

Verification
REQ-034 Test: FFT only, req_len0 = 2, data 0x1111 then 0x2222, tx_done pulses -> data_out sequence 0x0200, 0x1111, 0x2222, three valid pulses, grant = 01 throughout, then IDLE.
REQ-035 Test: both requesters asserted with len 1 from reset -> FFT packet first, then FIR header 0x0101, grants alternate 01 then 10.
REQ-036 Test: tx_done held high, or pulsed during FETCH -> no extra word and no cnt advance; only edges seen in WAIT count.
REQ-037 Test: FIR granted, src_valid1 never asserted -> timeout_err = 1 exactly TIMEOUT cycles after FETCH entry, grant = 00, next grant goes to FFT.
REQ-038 Test: rstb low during word 3 of 5 -> all outputs 0 immediately; after release, the same request restarts from its header.
REQ-039 Test: req_len0 = 0 with req0 high -> no grant, busy stays 0; req_len0 = 255 -> 256 words sent.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the transmit arbiter: FSM state encoding,
// source mode codes and the header word layout.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    WAIT  = 2'd2,
    FETCH = 2'd3
  } arb_state_t;

  localparam logic [1:0] MODE_FFT = 2'b00;
  localparam logic [1:0] MODE_FIR = 2'b01;

  localparam int DEFAULT_TIMEOUT = 255;

  // Header: [15:8] payload length, [7:2] zero, [1:0] source mode.
  function automatic logic [15:0] make_header(input logic [7:0] len, input logic [1:0] mode);
    return {len, 6'b000000, mode};
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; the history flop updates on the falling
// clock edge, matching the rest of the arbiter.
module rise_detect (
  input  logic clk,
  input  logic rstb,
  input  logic d,
  output logic rise
);

  logic d_prev;

  always_ff @(negedge clk or negedge rstb) begin
    if (!rstb) d_prev <= 1'b0;
    else       d_prev <= d;
  end

  assign rise = d & ~d_prev;

endmodule

// File: rtl/tx_arbiter.sv
// Two-source (FFT/FIR) packet arbiter feeding a single transmitter: sends a
// header then req_len payload words, one word per tx_done rising edge.
module tx_arbiter
  import core_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] req_len0,
  input  logic [LEN_W-1:0] req_len1,
  input  logic [15:0]      src_data0,
  input  logic [15:0]      src_data1,
  input  logic             src_valid0,
  input  logic             src_valid1,
  output logic             src_ready0,
  output logic             src_ready1,
  output logic [1:0]       grant,
  input  logic             tx_done,
  output logic [15:0]      data_out,
  output logic             data_out_valid,
  output logic             busy,
  output logic             timeout_err,
  output logic [1:0]       state_dbg
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  arb_state_t       state_q, state_d;
  logic             src_q, src_d;        // 0 = FFT, 1 = FIR
  logic             ptr_q, ptr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  tcnt_q, tcnt_d;
  logic [1:0]       grant_q, grant_d;
  logic [15:0]      data_q, data_d;
  logic             terr_q, terr_d;

  logic tx_rise;
  logic elig0, elig1, pick1, fetch_valid;

  rise_detect u_tx_rise (
    .clk  (clk),
    .rstb (rstb),
    .d    (tx_done),
    .rise (tx_rise)
  );

  assign elig0       = req[0] && (req_len0 != '0);
  assign elig1       = req[1] && (req_len1 != '0);
  assign pick1       = elig1 && (!elig0 || ptr_q);
  assign fetch_valid = src_q ? src_valid1 : src_valid0;

  always_ff @(negedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      src_q   <= 1'b0;
      ptr_q   <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      grant_q <= 2'b00;
      data_q  <= 16'h0000;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    grant_d = grant_q;
    data_d  = data_q;
    terr_d  = terr_q;
    case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          src_d   = pick1;
          len_d   = pick1 ? req_len1 : req_len0;
          cnt_d   = '0;
          grant_d = pick1 ? 2'b10 : 2'b01;
          data_d  = make_header(8'(pick1 ? req_len1 : req_len0), pick1 ? MODE_FIR : MODE_FFT);
          state_d = SEND;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (tx_rise) begin
          if (cnt_q == len_q) begin
            grant_d = 2'b00;
            ptr_d   = ~src_q;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + LEN_W'(1);
            tcnt_d  = '0;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        // A word transfers in any cycle where ready (FETCH, granted source) and valid are both high.
        if (fetch_valid) begin
          data_d  = src_q ? src_data1 : src_data0;
          state_d = SEND;
        end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          grant_d = 2'b00;
          ptr_d   = ~src_q;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant          = grant_q;
  assign data_out       = data_q;
  assign timeout_err    = terr_q;
  assign busy           = (state_q != IDLE);
  assign data_out_valid = (state_q == SEND);
  assign src_ready0     = (state_q == FETCH) && !src_q;
  assign src_ready1     = (state_q == FETCH) && src_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: an expected-word queue (data + owner) checked
// on every data_out_valid, plus per-cycle ownership, idle and error checks.
module tb_tx_arbiter;
  import core_pkg::*;

  localparam int TO = 16;

  logic        clk;
  logic        rstb;
  logic [1:0]  req;
  logic [7:0]  req_len0, req_len1;
  logic [15:0] src_data0, src_data1;
  logic        src_valid0, src_valid1;
  logic        src_ready0, src_ready1;
  logic [1:0]  grant;
  logic        tx_done;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic        busy;
  logic        timeout_err;
  logic [1:0]  state_dbg;

  tx_arbiter #(.LEN_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rstb(rstb), .req(req), .req_len0(req_len0), .req_len1(req_len1),
    .src_data0(src_data0), .src_data1(src_data1),
    .src_valid0(src_valid0), .src_valid1(src_valid1),
    .src_ready0(src_ready0), .src_ready1(src_ready1),
    .grant(grant), .tx_done(tx_done), .data_out(data_out),
    .data_out_valid(data_out_valid), .busy(busy),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [15:0] exp_q[$];
  logic [1:0]  exp_gq[$];
  logic [1:0]  cur_owner = 2'b00;
  logic        exp_terr  = 1'b0;
  bit          terr_x    = 1'b0;
  int          checks    = 0;
  int          errors    = 0;
  int          words_seen = 0;

  // stimulus environment
  logic [15:0] src_q0[$], src_q1[$];
  int          src_delay = 0;
  int          w0 = 0, w1 = 0;
  bit          tx_auto = 1'b1;
  logic        tx_man  = 1'b0;
  logic        tx_auto_v = 1'b0;
  int          tx_age  = 100;

  assign tx_done = tx_auto ? tx_auto_v : tx_man;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // transmitter: tx_done high on the 2nd and 3rd posedge after each new word
  always @(posedge clk) begin
    if (data_out_valid) tx_age = 0;
    else if (tx_age < 100) tx_age++;
    tx_auto_v = (tx_age == 2 || tx_age == 3);
  end

  // sources: answer ready after src_delay cycles with the next queued word
  always @(posedge clk) begin
    if (src_ready0 && src_q0.size() > 0) begin
      if (w0 < src_delay) begin w0++; src_valid0 = 1'b0; end
      else begin src_valid0 = 1'b1; src_data0 = src_q0.pop_front(); w0 = 0; end
    end else begin
      src_valid0 = 1'b0; w0 = 0;
    end
    if (src_ready1 && src_q1.size() > 0) begin
      if (w1 < src_delay) begin w1++; src_valid1 = 1'b0; end
      else begin src_valid1 = 1'b1; src_data1 = src_q1.pop_front(); w1 = 0; end
    end else begin
      src_valid1 = 1'b0; w1 = 0;
    end
  end

  // compare process
  always @(posedge clk) begin
    logic [15:0] e;
    logic [1:0]  g;
    if (!rstb) begin
      chk("reset_outputs", {grant, src_ready0, src_ready1, data_out, data_out_valid, busy, timeout_err}, 32'h0);
    end else begin
      if (data_out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %h expected none", data_out);
        end else begin
          e = exp_q.pop_front();
          g = exp_gq.pop_front();
          cur_owner = g;
          words_seen++;
          chk("word_data", data_out, e);
          chk("word_grant", grant, g);
        end
      end
      if (busy) chk("grant_owner", grant, cur_owner);
      else      chk("idle_grant", grant, 2'b00);
      if (src_ready0 || src_ready1) chk("ready_owner", {src_ready1, src_ready0}, cur_owner);
      if (!terr_x) chk("timeout_err", timeout_err, exp_terr);
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic push_pkt(input logic [1:0] owner, input logic [15:0] hdr, input int n, input logic [15:0] base);
    exp_q.push_back(hdr);
    exp_gq.push_back(owner);
    for (int i = 1; i <= n; i++) begin
      exp_q.push_back(base + 16'(i));
      exp_gq.push_back(owner);
      if (owner == 2'b01) src_q0.push_back(base + 16'(i));
      else                src_q1.push_back(base + 16'(i));
    end
  endtask

  task automatic wait_busy(input logic v, input int bound, input string name);
    int n = 0;
    while (busy !== v && n < bound) begin @(posedge clk); n++; end
    chk(name, busy, v);
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < bound) begin @(posedge clk); #1; n++; end
    chk({name, "_left"}, exp_q.size(), 0);
    chk({name, "_idle"}, busy, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rstb = 1'b0;
    exp_q.delete(); exp_gq.delete(); src_q0.delete(); src_q1.delete();
    exp_terr = 1'b0;
    tick(2); #2;
    rstb = 1'b1;
    words_seen = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int n;
    rstb = 1'b1; req = 2'b00; req_len0 = 8'd0; req_len1 = 8'd0;
    src_data0 = 16'h0; src_data1 = 16'h0; src_valid0 = 1'b0; src_valid1 = 1'b0;
    #1 rstb = 1'b0;
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_data_out", data_out, 16'h0000);
    chk("rst_valid", data_out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", timeout_err, 1'b0);
    chk("rst_ready", {src_ready1, src_ready0}, 2'b00);
    chk("rst_state", state_dbg, IDLE);
    tick(3); #2 rstb = 1'b1;

    // FFT only, two payload words
    words_seen = 0; src_delay = 2;
    exp_q.push_back(16'h0200); exp_gq.push_back(2'b01);
    exp_q.push_back(16'h1111); exp_gq.push_back(2'b01);
    exp_q.push_back(16'h2222); exp_gq.push_back(2'b01);
    src_q0.push_back(16'h1111); src_q0.push_back(16'h2222);
    req_len0 = 8'd2; req = 2'b01;
    wait_busy(1'b1, 20, "t034_grant");
    req = 2'b00;
    drain("t034", 200);
    chk("t034_words", words_seen, 3);

    // both requesters from reset: FFT first, then FIR after one idle cycle
    do_reset();
    src_delay = 0;
    push_pkt(2'b01, 16'h0100, 1, 16'h3000);
    push_pkt(2'b10, 16'h0101, 1, 16'h4000);
    req_len0 = 8'd1; req_len1 = 8'd1; req = 2'b11;
    wait_busy(1'b1, 20, "t035_first_grant");
    chk("t035_first_owner", grant, 2'b01);
    req = 2'b10;
    wait_busy(1'b0, 100, "t035_first_end");
    n = 0;
    while (!busy && n < 20) begin n++; @(posedge clk); end
    chk("t035_idle_gap", n, 1);
    chk("t035_second_owner", grant, 2'b10);
    req = 2'b00;
    drain("t035", 100);
    chk("t035_words", words_seen, 4);

    // tx_done held high, then pulsed during FETCH: only WAIT edges count
    words_seen = 0; tx_auto = 1'b0; tx_man = 1'b0; src_delay = 6;
    push_pkt(2'b01, 16'h0200, 2, 16'h5000);
    req_len0 = 8'd2; req = 2'b01;
    wait_busy(1'b1, 20, "t036_grant");
    req = 2'b00;
    tick(2); tx_man = 1'b1;
    tick(16); #1;
    chk("t036_held_words", words_seen, 2);
    chk("t036_held_busy", busy, 1'b1);
    tx_man = 1'b0; tick(2);
    tx_man = 1'b1; tick(1); tx_man = 1'b0;
    tick(2); tx_man = 1'b1; tick(1); tx_man = 1'b0;
    tick(12); #1;
    chk("t036_fetch_pulse_words", words_seen, 3);
    chk("t036_fetch_pulse_busy", busy, 1'b1);
    tx_man = 1'b1; tick(1); tx_man = 1'b0;
    wait_busy(1'b0, 10, "t036_end");
    drain("t036", 20);
    tx_auto = 1'b1; src_delay = 0;

    // FIR source never supplies a word: timeout after exactly TO cycles
    words_seen = 0; terr_x = 1'b1;
    exp_q.push_back(16'h0101); exp_gq.push_back(2'b10);
    req_len1 = 8'd1; req = 2'b10;
    wait_busy(1'b1, 20, "t037_grant");
    req = 2'b00;
    n = 0;
    while (!src_ready1 && n < 20) begin @(posedge clk); n++; end
    chk("t037_fetch_entry", src_ready1, 1'b1);
    n = 0;
    while (!timeout_err && n < TO + 10) begin @(posedge clk); n++; end
    chk("t037_timeout_cycles", n, TO);
    chk("t037_grant_cleared", grant, 2'b00);
    chk("t037_ready_cleared", src_ready1, 1'b0);
    exp_terr = 1'b1; terr_x = 1'b0;
    push_pkt(2'b01, 16'h0100, 1, 16'h7000);
    req_len0 = 8'd1; req_len1 = 8'd1; req = 2'b11;
    wait_busy(1'b1, 20, "t037_next");
    chk("t037_next_owner", grant, 2'b01);
    req = 2'b00;
    drain("t037", 100);

    // reset during payload word 3 of 5, then restart from the header
    words_seen = 0;
    push_pkt(2'b01, 16'h0500, 5, 16'h8000);
    req_len0 = 8'd5; req = 2'b01;
    n = 0;
    while (words_seen < 4 && n < 200) begin @(posedge clk); #1; n++; end
    chk("t038_reached_word3", words_seen, 4);
    #2 rstb = 1'b0;
    #1;
    chk("t038_rst_grant", grant, 2'b00);
    chk("t038_rst_data", data_out, 16'h0000);
    chk("t038_rst_busy", busy, 1'b0);
    chk("t038_rst_ready", {src_ready1, src_ready0}, 2'b00);
    chk("t038_rst_valid", data_out_valid, 1'b0);
    chk("t038_rst_timeout", timeout_err, 1'b0);
    exp_q.delete(); exp_gq.delete(); src_q0.delete();
    exp_terr = 1'b0;
    tick(2); #2 rstb = 1'b1;
    words_seen = 0;
    push_pkt(2'b01, 16'h0500, 5, 16'h8000);
    wait_busy(1'b1, 20, "t038_regrant");
    req = 2'b00;
    drain("t038", 200);
    chk("t038_words", words_seen, 6);

    // zero-length request is ignored
    req_len0 = 8'd0; req = 2'b01;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      chk("t039_len0_busy", busy, 1'b0);
    end
    req = 2'b00;

    // maximum-length packet: header + 255 words
    words_seen = 0;
    push_pkt(2'b01, 16'hFF00, 255, 16'hC000);
    req_len0 = 8'd255; req = 2'b01;
    wait_busy(1'b1, 20, "t039_grant");
    req = 2'b00;
    drain("t039", 5000);
    chk("t039_words", words_seen, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
